// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction fetches and data loads onto one single-beat AXI read channel.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed data-over-inst priority.
module axi_rd_arbiter #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  INST_ID = 4'd0,
  parameter logic [3:0]  DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_rd_req,
  input  logic [ADDR_W-1:0] inst_rd_addr,
  output logic              inst_rd_rdy,
  output logic              inst_rdata_vld,
  input  logic              data_rd_req,
  input  logic [ADDR_W-1:0] data_rd_addr,
  input  logic [2:0]        data_rd_size,
  output logic              data_rd_rdy,
  output logic              data_rdata_vld,
  output logic [DATA_W-1:0] rdata,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic              stallreq_axi,
  output logic [1:0]        dbg_state
);

  // Handshakes: AR transfers on arvalid & arready; R transfers on rvalid & rready.
  // Requesters hold *_rd_req until the one-cycle *_rd_rdy pulse accepts it.
  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner_data;
  logic   grant, grant_data, beat_ok, any_req;

  assign any_req = inst_rd_req | data_rd_req;

`ifdef ARB_RR_EN
  logic last_data;

  // On contention the requester not granted last wins; reset favours data first.
  assign grant_data = data_rd_req & (~inst_rd_req | ~last_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_data <= 1'b0;
    else if (grant) last_data <= grant_data;
  end
`else
  assign grant_data = data_rd_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    stallreq_axi = 1'b0;
    beat_ok      = 1'b0;
    case (state)
      IDLE: begin
        grant        = any_req & ~reset;
        stallreq_axi = any_req & ~reset;
        if (grant) state_nxt = AR;
      end
      AR: begin
        arvalid      = 1'b1;
        stallreq_axi = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready       = 1'b1;
        stallreq_axi = 1'b1;
        beat_ok      = rvalid & (rid == arid);
        if (beat_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_rd_rdy = grant & grant_data;
  assign inst_rd_rdy = grant & ~grant_data;
  assign dbg_state   = state;

  // Beats with a foreign rid are accepted by rready and simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr         <= '0;
      arsize         <= '0;
      arid           <= '0;
      owner_data     <= 1'b0;
      rdata          <= '0;
      inst_rdata_vld <= 1'b0;
      data_rdata_vld <= 1'b0;
    end else begin
      inst_rdata_vld <= 1'b0;
      data_rdata_vld <= 1'b0;
      if (grant) begin
        araddr     <= grant_data ? data_rd_addr : inst_rd_addr;
        arsize     <= grant_data ? data_rd_size : 3'b010;
        arid       <= grant_data ? DATA_ID : INST_ID;
        owner_data <= grant_data;
      end
      if (beat_ok) begin
        rdata          <= axi_rdata;
        inst_rdata_vld <= ~owner_data;
        data_rdata_vld <= owner_data;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scoreboard bench for axi_rd_arbiter (define ARB_RR_EN to check round-robin order).
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, inst_rd_rdy, inst_rdata_vld;
  logic [31:0] inst_rd_addr;
  logic        data_rd_req, data_rd_rdy, data_rdata_vld;
  logic [31:0] data_rd_addr;
  logic [2:0]  data_rd_size;
  logic [31:0] rdata, araddr, axi_rdata;
  logic [3:0]  arid, rid;
  logic [2:0]  arsize;
  logic        arvalid, arready, rvalid, rready, stallreq_axi;
  logic [1:0]  dbg_state;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_addr(inst_rd_addr), .inst_rd_rdy(inst_rd_rdy),
    .inst_rdata_vld(inst_rdata_vld),
    .data_rd_req(data_rd_req), .data_rd_addr(data_rd_addr), .data_rd_size(data_rd_size),
    .data_rd_rdy(data_rd_rdy), .data_rdata_vld(data_rdata_vld),
    .rdata(rdata), .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .rid(rid), .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
    .stallreq_axi(stallreq_axi), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // scoreboard queues: grant {data_rdy,inst_rdy}; AR {arid,arsize,araddr}; R {data_vld,inst_vld,rdata}
  logic [1:0]  grant_q[$];
  logic [38:0] ar_q[$];
  logic [33:0] exp_q[$];
  logic [31:0] slave_data_q[$];

  int ar_wait = 0;
  int bad_beats = 0;
  bit no_r = 0;

  int vld_cyc, inst_grant_cyc, data_vld_cyc;
  logic vld_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_txn(input bit is_data, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input bit with_rsp);
    grant_q.push_back(is_data ? 2'b10 : 2'b01);
    ar_q.push_back({is_data ? 4'd1 : 4'd0, is_data ? size : 3'd2, addr});
    if (with_rsp) begin
      exp_q.push_back({is_data, ~is_data, data});
      slave_data_q.push_back(data);
    end
  endtask

  // driver tasks: called just after a rising edge, return just after the granting edge
  task automatic drive_inst(input logic [31:0] addr);
    bit ok = 0;
    inst_rd_req = 1'b1; inst_rd_addr = addr;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = inst_rd_rdy;
      tick();
    end
    inst_rd_req = 1'b0;
    if (!ok) fail_now("inst_grant_timeout");
  endtask

  task automatic drive_data(input logic [31:0] addr, input logic [2:0] size);
    bit ok = 0;
    data_rd_req = 1'b1; data_rd_addr = addr; data_rd_size = size;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = data_rd_rdy;
      tick();
    end
    data_rd_req = 1'b0;
    if (!ok) fail_now("data_grant_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || ar_q.size() != 0 || grant_q.size() != 0 || dbg_state != 2'd0)
           && n < 200) begin
      tick(); n++;
    end
    if (n >= 200) fail_now("wait_done");
    repeat (2) tick();
  endtask

  // AXI slave model: directed AR delay, optional wrong-rid beats, echoes arid
  initial begin
    logic [3:0] cur_id;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; axi_rdata = 32'd0;
    forever begin
      tick();
      if (arvalid && !reset) begin
        for (int i = 0; i < ar_wait; i++) tick();
        arready = 1'b1; cur_id = arid;
        tick();
        arready = 1'b0;
        if (!no_r) begin
          for (int i = 0; i < bad_beats; i++) begin
            rvalid = 1'b1; rid = 4'd3; axi_rdata = 32'hdead_beef;
            tick();
          end
          rvalid = 1'b1; rid = cur_id;
          axi_rdata = (slave_data_q.size() != 0) ? slave_data_q.pop_front() : 32'h0;
          tick();
          rvalid = 1'b0; rid = 4'd0;
        end
      end
    end
  end

  // monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset && (inst_rd_rdy || data_rd_rdy)) begin
      if (inst_rd_rdy) inst_grant_cyc = cyc;
      if (grant_q.size() == 0) fail_now("unexpected_grant");
      else check("grant", {data_rd_rdy, inst_rd_rdy}, grant_q.pop_front());
    end
    if (!reset && arvalid && arready) begin
      if (ar_q.size() == 0) fail_now("unexpected_ar");
      else check("ar_fields", {arid, arsize, araddr}, ar_q.pop_front());
    end
    if (!reset && (inst_rdata_vld || data_rdata_vld)) begin
      vld_cyc = cyc; vld_stall = stallreq_axi;
      if (data_rdata_vld) data_vld_cyc = cyc;
      if (exp_q.size() == 0) fail_now("unexpected_rdata_vld");
      else check("rdata", {data_rdata_vld, inst_rdata_vld, rdata}, exp_q.pop_front());
    end
  end

  initial begin
    int t0;
    reset = 1'b1;
    inst_rd_req = 1'b0; inst_rd_addr = 32'd0;
    data_rd_req = 1'b0; data_rd_addr = 32'd0; data_rd_size = 3'd0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs",
          {arvalid, rready, stallreq_axi, inst_rdata_vld, data_rdata_vld, inst_rd_rdy, data_rd_rdy},
          7'd0);
    check("reset_regs", {rdata, araddr, arid, arsize, dbg_state}, 73'd0);
    tick();
    reset = 1'b0;
    tick();

    // single fetch, immediate slave: rdata_vld three cycles after the request
    expect_txn(0, 32'h1c00_0000, 3'd2, 32'h0280_0000, 1);
    t0 = cyc;
    drive_inst(32'h1c00_0000);
    wait_done();
    check("fetch_latency", vld_cyc - t0, 3);
    check("stall_low_at_vld", vld_stall, 1'b0);

    // fetch and load together: load first, fetch granted in the load's vld cycle
    expect_txn(1, 32'h8000_0010, 3'd0, 32'ha5a5_0001, 1);
    expect_txn(0, 32'h1c00_0004, 3'd2, 32'h5a5a_0002, 1);
    fork
      drive_data(32'h8000_0010, 3'd0);
      drive_inst(32'h1c00_0004);
    join
    wait_done();
    check("back_to_back_grant", inst_grant_cyc, data_vld_cyc);

    // arready held low for five cycles
    ar_wait = 5;
    expect_txn(0, 32'h1c00_0100, 3'd2, 32'h1234_5678, 1);
    drive_inst(32'h1c00_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ar_hold_valid", arvalid, 1'b1);
      check("ar_hold_addr", araddr, 32'h1c00_0100);
      check("ar_hold_stall", stallreq_axi, 1'b1);
    end
    wait_done();
    ar_wait = 0;

    // wrong rid beat discarded before the correct one
    bad_beats = 1;
    expect_txn(1, 32'h8000_0020, 3'd2, 32'hcafe_f00d, 1);
    t0 = cyc;
    drive_data(32'h8000_0020, 3'd2);
    wait_done();
    check("bad_rid_latency", vld_cyc - t0, 4);
    bad_beats = 0;

    // reset while waiting in R
    no_r = 1;
    expect_txn(0, 32'h1c00_0200, 3'd2, 32'h0, 0);
    drive_inst(32'h1c00_0200);
    begin
      int n = 0;
      while (dbg_state != 2'd2 && n < 50) begin tick(); n++; end
      if (n >= 50) fail_now("reach_r_state");
    end
    reset = 1'b1;
    #1;
    check("reset_in_r_state", dbg_state, 2'd0);
    check("reset_in_r_ctrl", {arvalid, rready, stallreq_axi, inst_rdata_vld, data_rdata_vld}, 5'd0);
    check("reset_in_r_regs", {rdata, araddr, arid, arsize}, 71'd0);
    repeat (2) tick();
    reset = 1'b0;
    no_r = 0;
    tick();

    // both requesters keep requesting for four transactions
`ifdef ARB_RR_EN
    expect_txn(1, 32'h8000_0100, 3'd1, 32'h1111_1111, 1);
    expect_txn(0, 32'h1c00_0010, 3'd2, 32'h2222_2222, 1);
    expect_txn(1, 32'h8000_0104, 3'd2, 32'h3333_3333, 1);
    expect_txn(0, 32'h1c00_0014, 3'd2, 32'h4444_4444, 1);
`else
    expect_txn(1, 32'h8000_0100, 3'd1, 32'h1111_1111, 1);
    expect_txn(1, 32'h8000_0104, 3'd2, 32'h3333_3333, 1);
    expect_txn(0, 32'h1c00_0010, 3'd2, 32'h2222_2222, 1);
    expect_txn(0, 32'h1c00_0014, 3'd2, 32'h4444_4444, 1);
`endif
    fork
      begin drive_data(32'h8000_0100, 3'd1); drive_data(32'h8000_0104, 3'd2); end
      begin drive_inst(32'h1c00_0010); drive_inst(32'h1c00_0014); end
    join
    wait_done();

    check("queues_drained", {grant_q.size() == 0, ar_q.size() == 0, exp_q.size() == 0}, 3'b111);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
